// File: rtl/jet_ts_pkg.sv
// jet_ts_pkg: shared state encodings and cluster-word layout
// for the per-phi-slice clustering scheduler.
package jet_ts_pkg;

  localparam int IDXW    = 5;
  localparam int PT_LSB  = 0;
  localparam int ETA_LSB = 9;
  localparam int XC_LSB  = 14;
  localparam int NT_LSB  = 18;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_FILL  = 3'd2,
    S_SEEK  = 3'd3,
    S_GRANT = 3'd4,
    S_FIN   = 3'd5
  } sched_state_e;

endpackage

// File: rtl/cl_mux_reg.sv
// cl_mux_reg: selects one slice's cluster stream by index
// and registers it with its phi tag.
module cl_mux_reg
  import jet_ts_pkg::*;
#(
  parameter int NPHI = 27,
  parameter int CLW  = 23
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [IDXW-1:0]     sel,
  input  logic [NPHI*CLW-1:0] cl_in,
  input  logic [NPHI-1:0]     vld_in,
  output logic [CLW-1:0]      cl_out,
  output logic [IDXW-1:0]     cl_phi,
  output logic                cl_valid
);

  logic [CLW-1:0]  cl_out_q, cl_out_d;
  logic [IDXW-1:0] cl_phi_q, cl_phi_d;
  logic            cl_valid_q, cl_valid_d;
  logic [CLW-1:0]  sel_cl;
  logic            sel_v;

  always_comb begin
    sel_cl = '0;
    sel_v  = 1'b0;
    for (int k = 0; k < NPHI; k++) begin
      if (sel == IDXW'(k)) begin
        sel_cl = cl_in[k*CLW +: CLW];
        sel_v  = vld_in[k];
      end
    end
    cl_valid_d = en & sel_v;
    cl_out_d   = en ? sel_cl : cl_out_q;
    cl_phi_d   = en ? sel : cl_phi_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cl_out_q   <= '0;
      cl_phi_q   <= '0;
      cl_valid_q <= 1'b0;
    end else begin
      cl_out_q   <= cl_out_d;
      cl_phi_q   <= cl_phi_d;
      cl_valid_q <= cl_valid_d;
    end
  end

  assign cl_out   = cl_out_q;
  assign cl_phi   = cl_phi_q;
  assign cl_valid = cl_valid_q;

endmodule

// File: rtl/phi_slice_sched.sv
// phi_slice_sched: per-event sequencer granting the shared
// merge-jets input to each enabled phi slice in turn.
module phi_slice_sched
  import jet_ts_pkg::*;
#(
  parameter int NPHI = 27,
  parameter int CLW  = 23,
  parameter int TMO  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                evt_start,
  input  logic                evt_stop,
  input  logic [NPHI-1:0]     slice_en,
  input  logic [NPHI-1:0]     slice_filled,
  input  logic [NPHI-1:0]     slice_done,
  input  logic [NPHI*CLW-1:0] slice_cl,
  input  logic [NPHI-1:0]     slice_cl_valid,
  output logic                start,
  output logic                stop,
  output logic [NPHI-1:0]     mj_ready,
  output logic [CLW-1:0]      cl_out,
  output logic [4:0]          cl_phi,
  output logic                cl_valid,
  output logic                evt_done,
  output logic [NPHI-1:0]     tmo_err,
  output logic [2:0]          state_out
);

  // one extra bit so idx can reach NPHI when NPHI is 32
  localparam int IW = IDXW + 1;

  sched_state_e    state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NPHI-1:0] en_q, en_d;
  logic [7:0]      tmr_q, tmr_d;
  logic [NPHI-1:0] mj_q, mj_d;
  logic [NPHI-1:0] tmo_q, tmo_d;
  logic            start_q, start_d;
  logic            stop_q, stop_d;
  logic            done_q, done_d;
  logic [IDXW-1:0] g_q, g_d;
  logic [1:0]      drain_q, drain_d;
  logic [NPHI-1:0] idx_oh;
  logic            en_hit, done_hit, fwd_en;

  always_comb begin
    idx_oh = '0;
    for (int k = 0; k < NPHI; k++) begin
      idx_oh[k] = (idx_q == IW'(k));
    end
  end

  assign en_hit   = |(en_q & idx_oh);
  assign done_hit = |(slice_done & idx_oh);
  assign fwd_en   = (state_q == S_GRANT) || (drain_q != 2'd0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    tmr_d   = tmr_q;
    mj_d    = mj_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    done_d  = 1'b0;
    g_d     = g_q;
    drain_d = (drain_q != 2'd0) ? drain_q - 2'd1 : 2'd0;
    if (evt_start) begin
      start_d = 1'b1;
      en_d    = slice_en;
      tmo_d   = '0;
      idx_d   = '0;
      mj_d    = '0;
      drain_d = 2'd0;
      state_d = S_READ;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_READ: begin
          if (evt_stop) begin
            stop_d  = 1'b1;
            state_d = S_FILL;
          end
        end
        S_FILL: begin
          if (en_q == '0) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else if ((slice_filled & en_q) == en_q) begin
            state_d = S_SEEK;
          end
        end
        S_SEEK: begin
          if (idx_q == IW'(NPHI)) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else if (en_hit) begin
            mj_d    = idx_oh;
            tmr_d   = '0;
            g_d     = idx_q[IDXW-1:0];
            drain_d = 2'd0;
            state_d = S_GRANT;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_GRANT: begin
          tmr_d = tmr_q + 8'd1;
          if (done_hit || tmr_q == 8'(TMO - 1)) begin
            if (!done_hit) tmo_d = tmo_q | idx_oh;
            mj_d    = '0;
            idx_d   = idx_q + IW'(1);
            drain_d = 2'd2;
            state_d = S_SEEK;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      en_q    <= '0;
      tmr_q   <= '0;
      mj_q    <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      g_q     <= '0;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      tmr_q   <= tmr_d;
      mj_q    <= mj_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      g_q     <= g_d;
      drain_q <= drain_d;
    end
  end

  cl_mux_reg #(
    .NPHI (NPHI),
    .CLW  (CLW)
  ) u_mux (
    .clk      (clk),
    .reset    (reset),
    .en       (fwd_en),
    .sel      (g_q),
    .cl_in    (slice_cl),
    .vld_in   (slice_cl_valid),
    .cl_out   (cl_out),
    .cl_phi   (cl_phi),
    .cl_valid (cl_valid)
  );

  assign start     = start_q;
  assign stop      = stop_q;
  assign mj_ready  = mj_q;
  assign evt_done  = done_q;
  assign tmo_err   = tmo_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_phi_slice_sched.sv
// tb_phi_slice_sched: randomized slice models against a
// timing/ordering reference derived from the grant rules.
module tb_phi_slice_sched;
  import jet_ts_pkg::*;

  localparam int NP  = 4;
  localparam int CW  = 23;
  localparam int TM  = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          evt_start, evt_stop;
  logic [NP-1:0] slice_en, slice_filled, slice_done;
  logic [NP*CW-1:0] slice_cl;
  logic [NP-1:0] slice_cl_valid;
  logic          start, stop, cl_valid, evt_done;
  logic [NP-1:0] mj_ready, tmo_err;
  logic [CW-1:0] cl_out;
  logic [4:0]    cl_phi;
  logic [2:0]    state_out;

  typedef struct {
    int         phi;
    logic [CW-1:0] w;
  } beat_t;

  beat_t        expq[$];
  int           dly[NP];
  logic [79:0]  emt[NP];
  int           n_test = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  phi_slice_sched #(
    .NPHI (NP),
    .CLW  (CW),
    .TMO  (TM)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .evt_start      (evt_start),
    .evt_stop       (evt_stop),
    .slice_en       (slice_en),
    .slice_filled   (slice_filled),
    .slice_done     (slice_done),
    .slice_cl       (slice_cl),
    .slice_cl_valid (slice_cl_valid),
    .start          (start),
    .stop           (stop),
    .mj_ready       (mj_ready),
    .cl_out         (cl_out),
    .cl_phi         (cl_phi),
    .cl_valid       (cl_valid),
    .evt_done       (evt_done),
    .tmo_err        (tmo_err),
    .state_out      (state_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_test++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cw(input int k, input int r);
    logic [CW-1:0] w;
    w = CW'((r & 31) << NT_LSB) | CW'(k << XC_LSB)
      | CW'(((r + 3*k) & 31) << ETA_LSB) | CW'((10*k) << PT_LSB);
    return w;
  endfunction

  // mode 0: full event; 1: restart when slice ak is 5 cycles
  // into its grant; 2: asynchronous reset at that point
  task automatic run_event(input logic [NP-1:0] en, input int mode,
                           input int ak);
    int L[NP], W[NP], gst[NP], glen[NP];
    int ord[$], eord[$];
    logic [NP-1:0] etmo, lowbit, mask;
    int sum, tf, dexp, ndone, dt, extra, bad_oh, rel;
    bit fin, ab;
    beat_t b;
    expq.delete();
    etmo = '0;
    sum  = 0;
    for (int k = 0; k < NP; k++) begin
      L[k] = (dly[k] <= TM) ? dly[k] : TM;
      if (en[k] && dly[k] > TM) etmo[k] = 1'b1;
      W[k] = (k + 1 < NP && en[(k+1)%NP]) ? L[k] + 1 : L[k] + 2;
      gst[k]  = -1;
      glen[k] = 0;
      sum += 1 + (en[k] ? L[k] : 0);
    end
    for (int k = 0; k < NP; k++) begin
      if (en[k]) begin
        eord.push_back(k);
        for (int r = 1; r <= W[k]; r++) begin
          if (emt[k][r]) begin
            b.phi = k;
            b.w   = cw(k, r);
            expq.push_back(b);
          end
        end
      end
    end
    tf     = 5 + $urandom_range(0, 6);
    dexp   = (en == '0) ? 6 : tf + 2 + sum;
    lowbit = en & (~en + NP'(1));
    ndone = 0; dt = -1; extra = 0; bad_oh = 0;
    fin = 1'b0; ab = 1'b0;
    for (int t = 0; t < 2000 && !fin && !ab; t++) begin
      @(negedge clk);
      if (t == 1) begin
        chk("start", 32'(start), 1);
        chk("st_read", 32'(state_out), 32'(S_READ));
        chk("mj_clr", 32'(mj_ready), 0);
        chk("tmo_clr", 32'(tmo_err), 0);
      end
      if (t == 5) begin
        chk("stop", 32'(stop), 1);
        chk("st_fill", 32'(state_out), 32'(S_FILL));
      end
      if (t >= 1) begin
        if (cl_valid) begin
          if (expq.size() == 0) extra++;
          else begin
            b = expq.pop_front();
            chk("cl_phi", 32'(cl_phi), 32'(b.phi));
            chk("cl_out", 32'(cl_out), 32'(b.w));
          end
        end
        if ($countones(mj_ready) > 1) bad_oh++;
        for (int k = 0; k < NP; k++) begin
          if (mj_ready[k]) begin
            if (gst[k] < 0) begin
              gst[k] = t;
              ord.push_back(k);
            end
            glen[k]++;
          end
        end
        if (evt_done) begin
          ndone++;
          if (dt < 0) dt = t;
        end
      end
      if (mode != 0 && gst[ak] >= 0 && t - gst[ak] + 1 == 5) begin
        ab = 1'b1;
      end else begin
        evt_start = (t == 0);
        evt_stop  = (t == 4);
        slice_en  = en;
        slice_filled = (t >= tf) ? (en | NP'($urandom))
                                 : (NP'($urandom) & ~lowbit);
        for (int k = 0; k < NP; k++) begin
          if (gst[k] >= 0) begin
            rel = t - gst[k] + 1;
            slice_done[k]     = (rel == dly[k]);
            slice_cl_valid[k] = (rel < 80) && emt[k][rel];
            slice_cl[k*CW +: CW] = cw(k, rel);
          end else begin
            slice_done[k]     = ($urandom_range(0, 3) == 0);
            slice_cl_valid[k] = ($urandom_range(0, 2) == 0);
            slice_cl[k*CW +: CW] = CW'($urandom);
          end
        end
        if (dt >= 0 && t >= dt + 4) fin = 1'b1;
      end
    end
    if (mode == 0) begin
      chk("evt_end", 32'(fin), 1);
      chk("evt_done_n", 32'(ndone), 1);
      chk("evt_done_t", 32'(dt), 32'(dexp));
      chk("tmo_err", 32'(tmo_err), 32'(etmo));
      chk("n_grant", 32'(ord.size()), 32'(eord.size()));
      for (int i = 0; i < ord.size() && i < eord.size(); i++)
        chk("grant_ord", 32'(ord[i]), 32'(eord[i]));
      for (int k = 0; k < NP; k++)
        chk("grant_len", 32'(glen[k]), en[k] ? 32'(L[k]) : 0);
      chk("cl_left", 32'(expq.size()), 0);
      chk("cl_extra", 32'(extra), 0);
      chk("mj_onehot", 32'(bad_oh), 0);
      chk("st_idle", 32'(state_out), 32'(S_IDLE));
    end else begin
      chk("abort_hit", 32'(ab), 1);
      mask = NP'((1 << ak) - 1);
      chk("tmo_pre", 32'(tmo_err), 32'(etmo & mask));
      slice_done     = '0;
      slice_cl_valid = '0;
      if (mode == 1) begin
        evt_start = 1'b1;
        @(negedge clk);
        evt_start = 1'b0;
        chk("rs_mj", 32'(mj_ready), 0);
        chk("rs_start", 32'(start), 1);
        chk("rs_state", 32'(state_out), 32'(S_READ));
        chk("rs_tmo", 32'(tmo_err), 0);
      end else begin
        #3 reset = 1'b1;
        #1;
        chk("ar_ctl", 32'({start, stop, evt_done, cl_valid, state_out,
                          mj_ready, tmo_err}), 0);
        chk("ar_cl", 32'({cl_phi, cl_out}), 0);
        @(negedge clk);
        reset = 1'b0;
      end
    end
    slice_done     = '0;
    slice_cl_valid = '0;
    evt_start      = 1'b0;
    evt_stop       = 1'b0;
  endtask

  task automatic set_all(input int d, input int e1, input int e2);
    for (int k = 0; k < NP; k++) begin
      dly[k] = d;
      emt[k] = '0;
      emt[k][e1] = 1'b1;
      emt[k][e2] = 1'b1;
    end
  endtask

  task automatic rand_slices();
    int r;
    for (int k = 0; k < NP; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      dly[k] = TM;
      else if (r == 1) dly[k] = TM + 1 + $urandom_range(0, 20);
      else             dly[k] = $urandom_range(1, 40);
      emt[k] = '0;
      for (int j = 1; j < 80; j++)
        emt[k][j] = ($urandom_range(0, 5) == 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    evt_start = 1'b0; evt_stop = 1'b0;
    slice_en = '0; slice_filled = '0; slice_done = '0;
    slice_cl = '0; slice_cl_valid = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", 32'({start, stop, evt_done, cl_valid, state_out,
                        mj_ready, tmo_err}), 0);
    chk("rst_cl", 32'({cl_phi, cl_out}), 0);
    reset = 1'b0;
    @(negedge clk);

    set_all(30, 5, 6);
    run_event(4'b1111, 0, 0);

    set_all(12, 3, 9);
    run_event(4'b1010, 0, 0);

    set_all(20, 1, 21);
    dly[2] = 300;
    run_event(4'b1111, 0, 0);

    set_all(5, 2, 6);
    dly[0] = 64; dly[1] = 65; dly[3] = 64;
    run_event(4'b1111, 0, 0);

    set_all(8, 9, 10);
    emt[0][11] = 1'b1;
    run_event(4'b0101, 0, 0);
    run_event(4'b0011, 0, 0);

    run_event(4'b0000, 0, 0);

    @(negedge clk);
    evt_stop = 1'b1;
    @(negedge clk);
    evt_stop = 1'b0;
    chk("idle_stop", 32'(stop), 0);
    chk("idle_state", 32'(state_out), 32'(S_IDLE));

    set_all(300, 2, 3);
    run_event(4'b0011, 1, 1);

    set_all(300, 2, 3);
    run_event(4'b0011, 2, 1);

    for (int i = 0; i < 12; i++) begin
      rand_slices();
      run_event(NP'($urandom), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule

// File: doc/phi_slice_sched.md
# phi_slice_sched

Per-event sequencer for the bank of per-phi-slice L1 clustering blocks in the jet-finding path. Broadcasts the event start/stop to all slices, then grants the shared merge-jets input to one slice at a time in ascending phi order through that slice's `mj_ready`. It forwards the granted slice's L1 clusters as one registered stream tagged with the phi index, and flags slices that fail to finish.

## Interface
Parameters:
- `NPHI`, 27: number of phi slices; 1..32.
- `CLW`, 23: L1 cluster word width, packed {ntrx[4:0], xcount[3:0], eta[4:0], pt[8:0]}.
- `TMO`, 64: cycles allowed from grant to slice `done` before abort; ≤255.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `evt_start`, in, 1: one-cycle pulse; new event begins.
- `evt_stop`, in, 1: one-cycle pulse; last track of event delivered.
- `slice_en`, in, NPHI: per-slice enable; sampled on `evt_start`.
- `slice_filled`, in, NPHI: per-slice `filled` (histogram complete).
- `slice_done`, in, NPHI: per-slice `done`.
- `slice_cl`, in, NPHI*CLW: per-slice cluster words; slice k at [k*CLW +: CLW].
- `slice_cl_valid`, in, NPHI: per-slice cluster valid.
- `start`, out, 1: broadcast start to slices.
- `stop`, out, 1: broadcast stop to slices.
- `mj_ready`, out, NPHI: one-hot grant, zero or one bit set.
- `cl_out`, out, CLW: forwarded cluster.
- `cl_phi`, out, 5: phi index of `cl_out`.
- `cl_valid`, out, 1: `cl_out`/`cl_phi` valid.
- `evt_done`, out, 1: one-cycle pulse; all enabled slices served.
- `tmo_err`, out, NPHI: sticky per-slice timeout flags; cleared on `evt_start`.
- `state_out`, out, 3: debug state.

## Operation
- All outputs reset to 0. State resets to IDLE, `idx` to 0, `en_q` to 0, timer to 0.
- States:
  - IDLE
  - READ
  - FILL: wait until all enabled slices have histograms filled.
  - SEEK: find the next enabled slice.
  - GRANT: grant held until the slice is done.
  - FIN
- `evt_start` in any state is a restart:
  - `start` pulses for 1 cycle, `en_q` <= `slice_en`, `tmo_err` <= 0, `idx` <= 0, `mj_ready` <= 0.
  - Next state is READ.
  - The restart takes priority over every other transition.
- READ: on `evt_stop`, `stop` pulses for 1 cycle and the next state is FILL. `evt_stop` outside READ is ignored.
- FILL: when (`slice_filled` & `en_q`) == `en_q`, go to SEEK. If `en_q` == 0, go directly to FIN.
- SEEK, 1 cycle per index:
  - If `idx` == NPHI, go to FIN.
  - Else if `en_q[idx]`, set `mj_ready[idx]`, clear the timer, and go to GRANT.
  - Else increment `idx` and stay in SEEK.
- GRANT:
  - Timer increments each cycle.
  - On `slice_done[idx]`: clear `mj_ready`, `idx`++, go to SEEK.
  - Else if timer == TMO-1: set `tmo_err[idx]`, clear `mj_ready`, `idx`++, go to SEEK.
  - If done and timeout occur in the same cycle, done wins and no error is flagged.
- FIN: `evt_done` pulses for 1 cycle, then go to IDLE.
- Cluster forwarding:
  - In GRANT, and for 2 cycles after leaving GRANT for the same `idx`, `cl_valid` <= `slice_cl_valid[g]`, `cl_out` <= `slice_cl[g]`, `cl_phi` <= g, where g is the last granted index.
  - This drain window catches trailing clusters.
  - Valids from non-granted slices are dropped.
  - The drain is cut short if the next grant starts sooner.
- `slice_done` of a non-granted slice is ignored.

## Timing
- `start` is high the cycle after `evt_start`. `stop` is high the cycle after `evt_stop`.
- `mj_ready[k]` is high from the cycle after SEEK selects k. It drops the cycle after `slice_done[k]` is sampled high.
- Cluster path latency: 1 cycle, from `slice_cl_valid` to `cl_valid`.
- Per-slice overhead: 1 SEEK cycle, plus 1 cycle per disabled index skipped.
- `evt_done` is high exactly 1 cycle after SEEK sees `idx` == NPHI.
- Reset mid-grant: all outputs are 0 immediately (asynchronous).

## Structure
- Shared package `jet_ts_pkg`:
  - State encodings.
  - Cluster-word field offsets (PT_LSB=0, ETA_LSB=9, XC_LSB=14, NT_LSB=18).
  - `IDXW`=5.
- Sub-module `cl_mux_reg`: NPHI:1 cluster mux with output register, index-selected.

## Test plan
- NPHI=4, all enabled, each slice asserts done 30 cycles after grant and emits 2 clusters (pt=10·k) → `mj_ready` goes 0001, 0010, 0100, 1000 in order; 8 `cl_valid` beats with `cl_phi` 0,0,1,1,2,2,3,3; one `evt_done`; `tmo_err`=0.
- `slice_en`=4'b1010 → only slices 1 and 3 granted; `mj_ready`[0],[2] never high; `evt_done` once.
- Slice 2 never asserts done, TMO=64 → `mj_ready[2]` drops after 64 cycles, `tmo_err`=4'b0100, slice 3 still served.
- `evt_start` while in GRANT on slice 1 → `mj_ready`=0 next cycle, `start` pulse, state READ, `tmo_err` cleared.
- Slice 0 cluster valid 1 cycle after its done → forwarded with `cl_phi`=0. Slice 2 valid while slice 0 is granted → dropped.
- `evt_stop` pulse in IDLE → no `stop` output, state stays IDLE.
